// File: rtl/img_stream_pkg.sv
// Shared encodings for the image-dump sequencer: FSM states, UART command bytes
// and the default number of writes per pixel.
package img_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [7:0] START_BYTE = 8'h53;
    localparam logic [7:0] ABORT_BYTE = 8'h58;
    localparam int         DEF_REPS   = 3;

endpackage

// File: rtl/img_stream_ctrl.sv
// Walks the image memory on a UART start command and pushes every grayscale
// pixel into the UART tx FIFO REPS times, honouring tx_full and an abort command.
module img_stream_ctrl
    import img_stream_pkg::*;
#(
    parameter int ADDR_BITS   = 13,
    parameter int PIXEL_COUNT = 8192,
    parameter int REPS        = DEF_REPS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    input  logic [7:0]           r_data,
    output logic                 rd_uart,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           pix_gray,
    output logic                 busy,
    output logic                 done
);

    localparam int                   REP_W     = $clog2(REPS + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXEL_COUNT - 1);
    localparam logic [REP_W-1:0]     LAST_REP  = REP_W'(REPS - 1);

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic [REP_W-1:0]     rep, rep_nxt;
    logic                 abort_q, abort_nxt;
    logic [7:0]           byte_q, byte_nxt;
    logic                 abort_hit, abort_now;

    always_comb begin
        // The rx FIFO is drained in every state except DONE; only IDLE acts on START.
        rd_uart   = !rx_empty && (state != ST_DONE);
        abort_hit = rd_uart && (state != ST_IDLE) && (r_data == ABORT_BYTE);
        abort_now = abort_q || abort_hit;
        wr_uart   = 1'b0;
        state_nxt = state;
        addr_nxt  = mem_addr;
        rep_nxt   = rep;
        abort_nxt = abort_q || abort_hit;
        byte_nxt  = byte_q;
        case (state)
            ST_IDLE: begin
                if (rd_uart && r_data == START_BYTE) begin
                    state_nxt = ST_FETCH;
                    addr_nxt  = '0;
                    rep_nxt   = '0;
                    abort_nxt = 1'b0;
                end
            end
            ST_FETCH: state_nxt = ST_FETCH == state ? ST_LATCH : state;
            ST_LATCH: begin
                byte_nxt  = pix_gray;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    rep_nxt = REP_W'(rep + 1'b1);
                    // Frame end wins over a pending abort on the very last write.
                    if (rep == LAST_REP && mem_addr == LAST_ADDR) begin
                        state_nxt = ST_DONE;
                    end else if (abort_now) begin
                        state_nxt = ST_IDLE;
                        abort_nxt = 1'b0;
                    end else if (rep == LAST_REP) begin
                        addr_nxt  = mem_addr + 1'b1;
                        rep_nxt   = '0;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                abort_nxt = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            rep      <= '0;
            abort_q  <= 1'b0;
            byte_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_addr <= addr_nxt;
            rep      <= rep_nxt;
            abort_q  <= abort_nxt;
            byte_q   <= byte_nxt;
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
        end
    end

    assign w_data = byte_q;

endmodule

// File: doc/img_stream_ctrl.md
# img_stream_ctrl

Sequencer that replaces the free-running address counter in the image-dump path. On a start command byte from the UART receiver it walks the image memory from address 0 to the last pixel, waits one cycle per address for the synchronous-read memory, and writes each grayscale byte (from the external black/white filter) into the UART transmit FIFO three times (R, G, B) under `tx_full` backpressure. It sits between the UART, the image memory, and the grayscale filter.

## Interface
Parameters:
- `ADDR_BITS`, 13: image memory address width.
- `PIXEL_COUNT`, 8192: pixels per frame; must satisfy 1 ≤ PIXEL_COUNT ≤ 2**ADDR_BITS.
- `REPS`, 3: writes per pixel; must be ≥ 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rx_empty` in 1: UART rx FIFO empty.
- `r_data` in 8: UART rx FIFO head byte, valid when `rx_empty`=0.
- `rd_uart` out 1: pops the rx FIFO head; 1-cycle pulse.
- `tx_full` in 1: UART tx FIFO full.
- `wr_uart` out 1: pushes `w_data` into the tx FIFO; asserted only when `tx_full`=0.
- `w_data` out 8: byte to transmit.
- `mem_addr` out ADDR_BITS: image memory read address (registered).
- `pix_gray` in 8: filter output; valid one cycle after `mem_addr` changes.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: 1-cycle pulse when a full frame has been sent.

## Operation
States: IDLE, FETCH, LATCH, SEND, DONE.
- **IDLE**
  - If `rx_empty`=0: pulse `rd_uart` and examine `r_data`.
  - On START_BYTE (8'h53): clear `mem_addr` and the rep count, then go to FETCH.
  - Any other byte is discarded and the block stays in IDLE.
- **FETCH**: `mem_addr` is stable and the memory samples it. Go to LATCH.
- **LATCH**: capture `pix_gray` into the byte register. Go to SEND.
- **SEND**
  - While `tx_full`=1: hold state, `wr_uart`=0.
  - When `tx_full`=0: `wr_uart`=1, `w_data`=byte register, rep count +1.
  - After the write with rep count = REPS-1:
    - If `mem_addr` = PIXEL_COUNT-1 (compared in full width; never relies on counter overflow): go to DONE.
    - Otherwise: `mem_addr` +1, rep count cleared, go to FETCH.
- **Abort**
  - In FETCH, LATCH and SEND: if `rx_empty`=0, pulse `rd_uart`.
  - If the popped byte is ABORT_BYTE (8'h58), set an abort flag. Other bytes, including START_BYTE, are discarded.
  - The flag is acted on only at the end of a SEND write: the block goes to IDLE without pulsing `done`. A byte already pushed is never retracted.
  - If the abort arrives in the same cycle as the final write of the frame, DONE takes priority and `done` pulses.
- **DONE**: pulse `done` for 1 cycle, clear the abort flag, go to IDLE.
- The byte register and `w_data` are unchanged between LATCH captures.
- The rep counter is `$clog2(REPS+1)` bits wide.

## Timing
- Reset values (`reset`=0 at a rising edge): state IDLE, `mem_addr`=0, rep=0, abort=0, byte register=0. Outputs: `rd_uart`=0, `wr_uart`=0, `w_data`=0, `busy`=0, `done`=0.
- Reset mid-frame takes effect on the next edge. No further `wr_uart` is issued and the frame is not resumed.
- `rd_uart` and `wr_uart` are combinational from state and FIFO flags. All other outputs are registered.
- Start latency: START_BYTE popped at cycle 0 → FETCH at cycle 1 → LATCH at cycle 2 → first `wr_uart` at cycle 3 (with `tx_full`=0).
- Per pixel without backpressure: REPS+2 cycles. A frame with no stalls takes PIXEL_COUNT·(REPS+2) cycles, plus 1 for DONE.
- `done` is asserted in the cycle after the final `wr_uart`. `busy` falls in the cycle after that.
- At most one `rd_uart` and one `wr_uart` per cycle. Both may be asserted in the same cycle.

## Structure
- Package `img_stream_pkg` holds:
  - the state encoding (IDLE, FETCH, LATCH, SEND, DONE);
  - the START_BYTE and ABORT_BYTE constants;
  - the default REPS.
- Single module, no sub-modules. The grayscale filter, memory, and UART are instantiated by the parent and are not part of this block.

## Test plan
- **Normal frame.** PIXEL_COUNT=4, memory gray values 10,20,30,40, `tx_full`=0; push 8'h53.
  - Expect `w_data` sequence 10,10,10,20,20,20,30,30,30,40,40,40.
  - First write at cycle 3 after the pop; `done` pulses once after the last write.
- **Non-start bytes.** Push 8'h41 then 8'h58 while idle.
  - Both are popped; no `wr_uart`; `busy` stays 0.
- **Backpressure.** Hold `tx_full`=1 for 5 cycles during the second write of pixel 1.
  - No `wr_uart` while full; the stream resumes with byte 20; total byte count is 12.
- **Abort.** Push 8'h58 during pixel 2.
  - The current write completes, the block returns to IDLE, `done` stays 0, and fewer than 12 bytes are sent.
- **Reset mid-frame.** Assert `reset`=0 during SEND.
  - Next cycle: all outputs at reset values, `mem_addr`=0.
  - A following 8'h53 restarts cleanly at pixel 0.
- **Full default frame.** PIXEL_COUNT=8192, ADDR_BITS=13.
  - Last address is 8191, no wrap to 0 before DONE, 24576 bytes sent.
  - Back-to-back start after `done` repeats the frame.
